// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Drives a 4-digit multiplexed 7-segment display from a 14-bit binary value.
// A sequential shift-add-3 engine converts the clamped value (max 9999) to BCD
// in 14 cycles. The finished result is copied into the display registers in a
// single edge, so a digit never shows a half-converted value. The scanner
// rotates the shared segment bus across the four anodes at SCAN_DIV clocks per
// digit and never stalls.
//
// Parameters:
//   SCAN_DIV    clocks per digit slot (2 .. 2^20)
//   ACTIVE_LOW  1: o_an/o_seg low-true (common anode), 0: high-true
//
// Ports:
//   i_clk    system clock
//   i_rst    synchronous reset, active-high, overrides everything
//   i_value  binary value to display (values above 9999 are clamped)
//   i_load   single-cycle strobe: sample i_value and start a conversion
//   o_busy   conversion in progress or pending
//   o_digit  index of the digit currently driven (0 = ones)
//   o_an     digit enables, one-hot at the logical level
//   o_seg    segments {g,f,e,d,c,b,a}
//
// Optional build macro:
//   SEG7_BLANK_LZ_EN  when defined, leading zeros in digit positions 1..3 are
//                     blanked; digit 0 is always shown.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic [1:0]  o_digit,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // ---------------------------------------------------------------- helpers
    function automatic logic [13:0] clamp_val(input logic [13:0] v);
        if (v > 14'd9999) begin
            clamp_val = 14'd9999;
        end else begin
            clamp_val = v;
        end
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        if (n >= 4'd5) begin
            add3 = n + 4'd3;
        end else begin
            add3 = n;
        end
    endfunction

    // Active-high gfedcba pattern for one BCD digit.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] p);
        if (ACTIVE_LOW) begin
            seg_pol = ~p;
        end else begin
            seg_pol = p;
        end
    endfunction

    function automatic logic [3:0] an_pol(input logic [1:0] d);
        logic [3:0] oh;
        case (d)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0001;
        endcase
        if (ACTIVE_LOW) begin
            an_pol = ~oh;
        end else begin
            an_pol = oh;
        end
    endfunction

`ifdef SEG7_BLANK_LZ_EN
    // Position k is blank when it and every higher digit are zero.
    function automatic logic blank_lz(input logic [15:0] d, input logic [1:0] k);
        case (k)
            2'd1:    blank_lz = (d[15:4]  == 12'd0);
            2'd2:    blank_lz = (d[15:8]  == 8'd0);
            2'd3:    blank_lz = (d[15:12] == 4'd0);
            default: blank_lz = 1'b0;
        endcase
    endfunction
`endif

    // ---------------------------------------------------------------- state
    logic [1:0]    state_q,    state_d;
    logic          busy_q;
    logic          pend_q,     pend_d;
    logic [13:0]   pend_val_q, pend_val_d;
    logic [13:0]   bin_q,      bin_d;
    logic [15:0]   bcd_q,      bcd_d;
    logic [3:0]    cnt_q,      cnt_d;
    logic [15:0]   disp_q,     disp_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic [1:0]    digit_q,    digit_d;
    logic [3:0]    an_q,       an_d;
    logic [6:0]    seg_q,      seg_d;

    logic [11:0]   adj_lo_s;
    logic [3:0]    nib_s;
    logic [6:0]    seg_pat_s;

    // Conversion FSM: capture, 14 shift-add-3 steps, atomic latch.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        // The thousands nibble can never reach 5 before the last shift (the
        // input is clamped to 9999), so only the lower three need adjusting
        // and nothing is lost off the top.
        adj_lo_s   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    bin_d   = clamp_val(i_value);
                    bcd_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (i_load) begin
                    pend_d     = 1'b1;
                    pend_val_d = clamp_val(i_value);
                end else begin
                    pend_d     = pend_q;
                end
                bcd_d = {bcd_q[14:12], adj_lo_s, bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                if (cnt_q == 4'd13) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_LATCH: begin
                disp_d = bcd_q;
                if (pend_q) begin
                    // Start the pending value; a load arriving now queues behind it.
                    bin_d      = pend_val_q;
                    bcd_d      = 16'd0;
                    cnt_d      = 4'd0;
                    state_d    = ST_CONV;
                    pend_d     = i_load;
                    pend_val_d = i_load ? clamp_val(i_value) : pend_val_q;
                end else if (i_load) begin
                    // A load in this cycle is pending and is consumed immediately.
                    bin_d   = clamp_val(i_value);
                    bcd_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Scanner: prescaler, digit index and the registered anode/segment values
    // for the digit that will be current after this edge.
    always_comb begin
        if (presc_q == PRESC_TC) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
            digit_d = digit_q;
        end

        case (digit_d)
            2'd0:    nib_s = disp_q[3:0];
            2'd1:    nib_s = disp_q[7:4];
            2'd2:    nib_s = disp_q[11:8];
            2'd3:    nib_s = disp_q[15:12];
            default: nib_s = 4'd0;
        endcase

`ifdef SEG7_BLANK_LZ_EN
        if (blank_lz(disp_q, digit_d)) begin
            seg_pat_s = 7'h00;
        end else begin
            seg_pat_s = glyph(nib_s);
        end
`else
        seg_pat_s = glyph(nib_s);
`endif

        an_d  = an_pol(digit_d);
        seg_d = seg_pol(seg_pat_s);
    end

    // All state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= 14'd0;
            bin_q      <= 14'd0;
            bcd_q      <= 16'd0;
            cnt_q      <= 4'd0;
            disp_q     <= 16'd0;
            presc_q    <= '0;
            digit_q    <= 2'd0;
            an_q       <= an_pol(2'd0);
            seg_q      <= seg_pol(glyph(4'd0));
        end else begin
            state_q    <= state_d;
            // Lags the state by one edge so it rises the edge after capture.
            busy_q     <= (state_q != ST_IDLE);
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_digit = digit_q;
    assign o_an    = an_q;
    assign o_seg   = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [13:0] value;
    logic        busy;
    logic [1:0]  digit;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_value (value),
        .i_load  (load),
        .o_busy  (busy),
        .o_digit (digit),
        .o_an    (an),
        .o_seg   (seg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand-written low-true patterns {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph_al(input logic [3:0] n);
        case (n)
            4'd0:    glyph_al = 7'b1000000;
            4'd1:    glyph_al = 7'b1111001;
            4'd2:    glyph_al = 7'b0100100;
            4'd3:    glyph_al = 7'b0110000;
            4'd4:    glyph_al = 7'b0011001;
            4'd5:    glyph_al = 7'b0010010;
            4'd6:    glyph_al = 7'b0000010;
            4'd7:    glyph_al = 7'b1111000;
            4'd8:    glyph_al = 7'b0000000;
            4'd9:    glyph_al = 7'b0010000;
            default: glyph_al = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int d);
        logic [15:0] hi;
        hi = bcd >> (4 * d);
`ifdef SEG7_BLANK_LZ_EN
        if (d > 0 && hi == 16'd0) return 7'b1111111;
`endif
        return glyph_al(hi[3:0]);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_digit"}, {30'd0, digit}, 32'd0);
        chk({tag, "_an"},    {28'd0, an},    {28'd0, 4'b1110});
        chk({tag, "_seg"},   {25'd0, seg},   {25'd0, 7'b1000000});
        chk({tag, "_busy"},  {31'd0, busy},  32'd0);
    endtask

    // Walk one full scan and compare every digit slot.
    task automatic check_disp(input string tag, input logic [15:0] bcd);
        for (int d = 0; d < 4; d++) begin
            int guard;
            logic [3:0] ean;
            guard = 0;
            while (digit !== d[1:0] && guard < 20) begin
                tick;
                guard++;
            end
            ean = ~(4'b0001 << d);
            chk($sformatf("%s_digit%0d", tag, d), {30'd0, digit}, d);
            chk($sformatf("%s_an%0d", tag, d), {28'd0, an}, {28'd0, ean});
            chk($sformatf("%s_seg%0d", tag, d), {25'd0, seg}, {25'd0, exp_seg(bcd, d)});
        end
    endtask

    task automatic do_load(input logic [13:0] v, output int busy_cycles);
        value = v;
        load  = 1'b1;
        tick;
        load  = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (busy) busy_cycles++;
            else break;
        end
    endtask

    initial begin
        int  bc;
        bit  seen42, seen5678, seen8;

        // 1. reset and scan cadence
        rst = 1'b1; load = 1'b0; value = 14'd0;
        tick; tick;
        check_reset("rst");
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] ean;
            repeat (4) tick;
            ean = ~(4'b0001 << (k % 4));
            chk($sformatf("scan_digit%0d", k), {30'd0, digit}, k % 4);
            chk($sformatf("scan_an%0d", k), {28'd0, an}, {28'd0, ean});
        end

        // 2. 1234: busy for exactly 15 cycles, then digits 4,3,2,1
        do_load(14'd1234, bc);
        chk("busy_len_1234", bc, 32'd15);
        check_disp("d1234", 16'h1234);

        // 3. saturation and zero
        do_load(14'd16383, bc);
        chk("busy_len_sat", bc, 32'd15);
        check_disp("dsat", 16'h9999);
        do_load(14'd0, bc);
        check_disp("dzero", 16'h0000);

        // 4. loads while busy: last one wins, no abort
        value = 14'd5678; load = 1'b1;
        tick;
        load = 1'b0;
        bc = 0; seen42 = 1'b0; seen5678 = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 3) begin
                value = 14'd42; load = 1'b1;
            end else if (i == 5) begin
                value = 14'd9001; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick;
            if (busy) bc++;
            if (digit == 2'd1 && seg == glyph_al(4'd4)) seen42 = 1'b1;
            if (seg == exp_seg(16'h5678, int'(digit))) seen5678 = 1'b1;
            if (!busy) break;
        end
        load = 1'b0;
        chk("busy_len_pend", bc, 32'd30);
        chk("never_0042", {31'd0, seen42}, 32'd0);
        chk("saw_5678", {31'd0, seen5678}, 32'd1);
        check_disp("d9001", 16'h9001);

        // 5. reset in the middle of converting 8888
        value = 14'd8888; load = 1'b1;
        tick;
        load = 1'b0;
        repeat (6) tick;
        rst = 1'b1;
        tick;
        check_reset("midrst");
        rst = 1'b0;
        seen8 = 1'b0; bc = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (seg == 7'b0000000) seen8 = 1'b1;
            if (busy) bc++;
        end
        chk("never_8888", {31'd0, seen8}, 32'd0);
        chk("no_busy_after_rst", bc, 32'd0);
        check_disp("dpost_rst", 16'h0000);

        // 6. small value (leading zeros blank only with the feature build)
        do_load(14'd7, bc);
        check_disp("d0007", 16'h0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
